// File: rtl/react_pkg.sv
// Shared types and constants for the reaction-time measurement stage.
// Holds the FSM encoding, BCD limits and a 4-digit BCD increment helper.
package react_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StTiming = 2'd1,
      StDone   = 2'd2
   } state_e;

   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned CNT_W      = DIGIT_W * NUM_DIGITS;

   localparam logic [CNT_W-1:0]   BCD_MAX  = 16'h9999;
   localparam logic [DIGIT_W-1:0] MISS_MAX = 4'hF;

   // Ripple a +1 through the BCD digits; each 9 becomes 0 and carries onward.
   function automatic logic [CNT_W-1:0] bcd_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      logic             carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (carry) begin
            if (v[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
               r[i*DIGIT_W +: DIGIT_W] = 4'd0;
            end else begin
               r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + 4'd1;
               carry                   = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd4_cnt.sv
// Four-digit BCD up-counter with synchronous clear that saturates at 9999.
// hit_max flags the increment that lands on 9999 so the caller can stop on that edge.
module bcd4_cnt
   import react_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             sat,
   output logic             hit_max
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_inc;

   assign count_inc = bcd_inc(count_q);
   assign sat       = (count_q == BCD_MAX);
   assign hit_max   = inc & ~clr & ~sat & (count_inc == BCD_MAX);
   assign count     = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !sat) begin
         count_d = count_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/react_timer.sv
// Reaction-time stage: counts ms from det_start until a lit key is pressed, freezes the
// BCD result on ctrl, pulses det_end, counts wrong-key presses and flags a 9.999 s timeout.
module react_timer
   import react_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned TICK_HZ  = 1000,
   parameter int unsigned KEY_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             restart,
   input  logic             det_start,
   input  logic [KEY_W-1:0] btn_deb,
   input  logic [KEY_W-1:0] bit_sel,
   output logic             det_end,
   output logic [15:0]      ctrl,
   output logic             busy,
   output logic             timeout,
   output logic [3:0]       miss_cnt
);

   localparam int unsigned PRESC_TERM = CLK_FREQ / TICK_HZ - 1;
   localparam int unsigned PRESC_W    = (PRESC_TERM > 0) ? $clog2(PRESC_TERM + 1) : 1;

   state_e             state_q;
   logic [PRESC_W-1:0] presc_q;
   logic [KEY_W-1:0]   key_q;
   logic [KEY_W-1:0]   press;
   logic               hit;
   logic               miss;
   logic               tick;
   logic               ctr_clr;
   logic               ctr_inc;
   logic               ctr_sat;
   logic               ctr_hit_max;

   // Key history tracks btn_deb continuously so a key held across det_start stays silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q <= '1;
      end else begin
         key_q <= btn_deb;
      end
   end

   assign press = key_q & ~btn_deb;
   assign hit   = |(press & bit_sel);
   assign miss  = |(press & ~bit_sel);
   assign tick  = (state_q == StTiming) && (presc_q == PRESC_W'(PRESC_TERM));

   // A hit on the tick edge freezes the count before that tick lands.
   assign ctr_clr = restart | (det_start & (state_q != StTiming));
   assign ctr_inc = ~restart & tick & ~hit;

   bcd4_cnt u_bcd4_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (ctr_clr),
      .inc     (ctr_inc),
      .count   (ctrl),
      .sat     (ctr_sat),
      .hit_max (ctr_hit_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         presc_q  <= '0;
         det_end  <= 1'b0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         miss_cnt <= '0;
      end else if (restart) begin
         state_q  <= StIdle;
         presc_q  <= '0;
         det_end  <= 1'b0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         miss_cnt <= '0;
      end else begin
         det_end <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (det_start) begin
                  state_q  <= StTiming;
                  busy     <= 1'b1;
                  presc_q  <= '0;
                  timeout  <= 1'b0;
                  miss_cnt <= '0;
               end
            end
            StTiming: begin
               if (hit) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
                  det_end <= 1'b1;
               end else if (ctr_hit_max || ctr_sat) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
                  det_end <= 1'b1;
                  timeout <= 1'b1;
               end else begin
                  presc_q <= tick ? '0 : presc_q + 1'b1;
                  if (miss && (miss_cnt != MISS_MAX)) begin
                     miss_cnt <= miss_cnt + 4'd1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_react_timer.sv
// Directed bench for react_timer using a 2-cycle ms tick to keep runs short.
// Expected values are hand-computed from tick positions relative to det_start.
module tb_react_timer;

   localparam int unsigned DIV = 2;

   logic        clk;
   logic        rst_n;
   logic        restart;
   logic        det_start;
   logic [7:0]  btn_deb;
   logic [7:0]  bit_sel;
   logic        det_end;
   logic [15:0] ctrl;
   logic        busy;
   logic        timeout;
   logic [3:0]  miss_cnt;

   int n_tests;
   int n_fail;

   react_timer #(
      .CLK_FREQ (2000),
      .TICK_HZ  (1000),
      .KEY_W    (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart   (restart),
      .det_start (det_start),
      .btn_deb   (btn_deb),
      .bit_sel   (bit_sel),
      .det_end   (det_end),
      .ctrl      (ctrl),
      .busy      (busy),
      .timeout   (timeout),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_run();
      det_start = 1'b1;
      tick_clk(1);
      det_start = 1'b0;
   endtask

   initial begin
      int cyc;
      int n_end;
      int first_end;
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      restart   = 1'b0;
      det_start = 1'b0;
      btn_deb   = 8'hFF;
      bit_sel   = 8'h04;
      tick_clk(3);
      rst_n = 1'b1;
      tick_clk(1);

      // Reset state
      check_eq("rst_ctrl", 32'(ctrl), 32'h0);
      check_eq("rst_det_end", 32'(det_end), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_timeout", 32'(timeout), 32'h0);
      check_eq("rst_miss", 32'(miss_cnt), 32'h0);

      // 1: hit after 1234 ticks
      start_run();
      check_eq("t1_busy", 32'(busy), 32'h1);
      tick_clk(DIV * 1234);
      check_eq("t1_pre_ctrl", 32'(ctrl), 32'h1234);
      btn_deb = 8'hFB;
      tick_clk(1);
      check_eq("t1_ctrl", 32'(ctrl), 32'h1234);
      check_eq("t1_det_end", 32'(det_end), 32'h1);
      check_eq("t1_busy_fall", 32'(busy), 32'h0);
      check_eq("t1_timeout", 32'(timeout), 32'h0);
      tick_clk(1);
      check_eq("t1_det_end_1cyc", 32'(det_end), 32'h0);
      btn_deb = 8'hFF;
      tick_clk(10);
      check_eq("t1_ctrl_held", 32'(ctrl), 32'h1234);

      // 2: two misses, ignored det_start, hit at tick 300
      start_run();
      cyc = 0;
      tick_clk(10);        cyc += 10;
      btn_deb = 8'hDF; tick_clk(1); cyc++;
      btn_deb = 8'hFF; tick_clk(1); cyc++;
      btn_deb = 8'hBF; tick_clk(1); cyc++;
      btn_deb = 8'hFF; tick_clk(1); cyc++;
      det_start = 1'b1; tick_clk(1); cyc++;
      det_start = 1'b0;
      check_eq("t2_busy", 32'(busy), 32'h1);
      check_eq("t2_miss_mid", 32'(miss_cnt), 32'h2);
      tick_clk(DIV * 300 - cyc);
      btn_deb = 8'hFB;
      tick_clk(1);
      check_eq("t2_ctrl", 32'(ctrl), 32'h0300);
      check_eq("t2_miss", 32'(miss_cnt), 32'h2);
      check_eq("t2_det_end", 32'(det_end), 32'h1);
      btn_deb = 8'hFF;
      tick_clk(1);

      // 3: bit_sel==0, saturating misses, then timeout at 9999
      bit_sel = 8'h00;
      start_run();
      cyc = 0;
      for (int k = 0; k < 17; k++) begin
         btn_deb = ~(8'h01 << (k % 8)); tick_clk(1); cyc++;
         btn_deb = 8'hFF;               tick_clk(1); cyc++;
      end
      check_eq("t3_miss_sat", 32'(miss_cnt), 32'hF);
      n_end     = 0;
      first_end = -1;
      while (cyc < int'(DIV) * 10000 + 20) begin
         tick_clk(1);
         cyc++;
         if (det_end) begin
            n_end++;
            if (first_end < 0) first_end = cyc;
         end
      end
      check_eq("t3_end_cycle", 32'(first_end), 32'(DIV * 9999));
      check_eq("t3_end_count", 32'(n_end), 32'h1);
      check_eq("t3_ctrl", 32'(ctrl), 32'h9999);
      check_eq("t3_timeout", 32'(timeout), 32'h1);
      check_eq("t3_busy", 32'(busy), 32'h0);
      tick_clk(50);
      check_eq("t3_ctrl_held", 32'(ctrl), 32'h9999);

      // 4: key held across det_start, then release and press at tick 50
      bit_sel = 8'h04;
      btn_deb = 8'hFB;
      tick_clk(2);
      start_run();
      check_eq("t4_timeout_clr", 32'(timeout), 32'h0);
      cyc = 0;
      tick_clk(DIV * 20); cyc += DIV * 20;
      check_eq("t4_no_hit", 32'(busy), 32'h1);
      btn_deb = 8'hFF; tick_clk(1); cyc++;
      tick_clk(DIV * 50 - cyc);
      btn_deb = 8'hFB;
      tick_clk(1);
      check_eq("t4_ctrl", 32'(ctrl), 32'h0050);
      check_eq("t4_det_end", 32'(det_end), 32'h1);

      // 5: hit on the same cycle as the tick that would reach 0100
      btn_deb = 8'hFF;
      tick_clk(1);
      start_run();
      tick_clk(DIV * 100 - 1);
      btn_deb = 8'hFB;
      tick_clk(1);
      check_eq("t5_hit_tick_ctrl", 32'(ctrl), 32'h0099);
      check_eq("t5_det_end", 32'(det_end), 32'h1);
      btn_deb = 8'hFF;
      tick_clk(1);

      // 5b: restart mid-TIMING after a miss
      start_run();
      tick_clk(30);
      btn_deb = 8'hBF; tick_clk(1);
      check_eq("t5_miss", 32'(miss_cnt), 32'h1);
      btn_deb = 8'hFF;
      restart = 1'b1; tick_clk(1);
      restart = 1'b0;
      check_eq("t5_rst_busy", 32'(busy), 32'h0);
      check_eq("t5_rst_ctrl", 32'(ctrl), 32'h0);
      check_eq("t5_rst_miss", 32'(miss_cnt), 32'h0);
      check_eq("t5_rst_det_end", 32'(det_end), 32'h0);
      n_end = 0;
      for (int k = 0; k < 10; k++) begin
         tick_clk(1);
         if (det_end) n_end++;
      end
      check_eq("t5_no_det_end", 32'(n_end), 32'h0);
      check_eq("t5_idle_ctrl", 32'(ctrl), 32'h0);
      restart = 1'b1; det_start = 1'b1; tick_clk(1);
      restart = 1'b0; det_start = 1'b0;
      check_eq("t5_restart_wins", 32'(busy), 32'h0);

      // 6: asynchronous reset mid-run, then a fresh run from 0000
      start_run();
      tick_clk(20);
      btn_deb = 8'hF7; tick_clk(1);
      check_eq("t6_miss", 32'(miss_cnt), 32'h1);
      #3 rst_n = 1'b0;
      #1;
      check_eq("t6_async_busy", 32'(busy), 32'h0);
      check_eq("t6_async_ctrl", 32'(ctrl), 32'h0);
      check_eq("t6_async_miss", 32'(miss_cnt), 32'h0);
      check_eq("t6_async_det_end", 32'(det_end), 32'h0);
      tick_clk(1);
      btn_deb = 8'hFF;
      rst_n   = 1'b1;
      tick_clk(1);
      start_run();
      tick_clk(DIV * 7);
      btn_deb = 8'hFB;
      tick_clk(1);
      check_eq("t6_ctrl", 32'(ctrl), 32'h0007);
      check_eq("t6_det_end", 32'(det_end), 32'h1);
      btn_deb = 8'hFF;
      tick_clk(1);

      // 7: multi-hot bit_sel, hit and miss on the same edge
      bit_sel = 8'h24;
      start_run();
      tick_clk(DIV * 5);
      btn_deb = 8'h5F;
      tick_clk(1);
      check_eq("t7_ctrl", 32'(ctrl), 32'h0005);
      check_eq("t7_det_end", 32'(det_end), 32'h1);
      check_eq("t7_miss", 32'(miss_cnt), 32'h0);
      btn_deb = 8'hFF;
      tick_clk(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
